// File: rtl/tx_control_fsm.sv
// USB packet transmit controller: sequences SYNC, PID, optional payload + CRC16, then EOP
// into the bit-level encoder, tracking the DATA0/DATA1 toggle across packets.
module tx_control_fsm #(
  parameter int MAX_BYTES = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [2:0] TX_packet,
  input  logic [6:0] buffer_occupancy,
  input  logic [7:0] tx_data,
  input  logic       byte_done,
  input  logic       eop_done,
  output logic [7:0] tx_byte,
  output logic       tx_load,
  output logic       get_tx_data,
  output logic       send_eop,
  output logic       tx_busy,
  output logic       tx_done
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LD_SYNC,
    ST_WT_SYNC,
    ST_LD_PID,
    ST_WT_PID,
    ST_LD_DATA,
    ST_WT_DATA,
    ST_LD_CRC1,
    ST_WT_CRC1,
    ST_LD_CRC2,
    ST_WT_CRC2,
    ST_EOP,
    ST_WT_EOP,
    ST_DONE
  } state_t;

  localparam logic [2:0] PKT_DATA  = 3'd1;
  localparam logic [2:0] PKT_ACK   = 3'd4;
  localparam logic [2:0] PKT_NAK   = 3'd5;
  localparam logic [2:0] PKT_STALL = 3'd7;

  state_t      r_state;
  state_t      w_state_next;
  logic [2:0]  r_code;
  logic [6:0]  r_len;
  logic [6:0]  r_cnt;
  logic [15:0] r_crc;
  logic        r_toggle;

  logic        w_req_valid;
  logic [6:0]  w_len_clamped;
  logic [15:0] w_crc_upd;
  logic        w_more_data;
  logic [15:0] w_crc_tx;
  logic [7:0]  w_pid_byte;

  assign w_req_valid   = (TX_packet == PKT_DATA) || (TX_packet == PKT_ACK) ||
                         (TX_packet == PKT_NAK)  || (TX_packet == PKT_STALL);
  assign w_len_clamped = (buffer_occupancy > 7'(MAX_BYTES)) ? 7'(MAX_BYTES) : buffer_occupancy;
  assign w_more_data   = (r_cnt < r_len);
  assign w_crc_tx      = ~r_crc;

  // Reflected CRC-16/USB, one whole byte per cycle (bit 0 first).
  always_comb begin
    w_crc_upd = r_crc ^ {8'h00, tx_data};
    for (int i = 0; i < 8; i++) begin
      w_crc_upd = w_crc_upd[0] ? ((w_crc_upd >> 1) ^ 16'hA001) : (w_crc_upd >> 1);
    end
  end

  always_comb begin
    case (r_code)
      PKT_ACK:   w_pid_byte = 8'hD2;
      PKT_NAK:   w_pid_byte = 8'h5A;
      PKT_STALL: w_pid_byte = 8'h1E;
      PKT_DATA:  w_pid_byte = r_toggle ? 8'h4B : 8'hC3;
      default:   w_pid_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    tx_byte      = 8'h00;
    tx_load      = 1'b0;
    get_tx_data  = 1'b0;
    send_eop     = 1'b0;
    tx_done      = 1'b0;
    tx_busy      = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        if (w_req_valid) w_state_next = ST_LD_SYNC;
      end
      ST_LD_SYNC: begin
        tx_load      = 1'b1;
        tx_byte      = 8'h80;
        w_state_next = ST_WT_SYNC;
      end
      ST_WT_SYNC: begin
        if (byte_done) w_state_next = ST_LD_PID;
      end
      ST_LD_PID: begin
        tx_load      = 1'b1;
        tx_byte      = w_pid_byte;
        w_state_next = ST_WT_PID;
      end
      ST_WT_PID: begin
        if (byte_done) begin
          if (r_code != PKT_DATA) w_state_next = ST_EOP;
          else if (w_more_data)   w_state_next = ST_LD_DATA;
          else                    w_state_next = ST_LD_CRC1;
        end
      end
      ST_LD_DATA: begin
        tx_load      = 1'b1;
        get_tx_data  = 1'b1;
        tx_byte      = tx_data;
        w_state_next = ST_WT_DATA;
      end
      ST_WT_DATA: begin
        if (byte_done) w_state_next = w_more_data ? ST_LD_DATA : ST_LD_CRC1;
      end
      ST_LD_CRC1: begin
        tx_load      = 1'b1;
        tx_byte      = w_crc_tx[7:0];
        w_state_next = ST_WT_CRC1;
      end
      ST_WT_CRC1: begin
        if (byte_done) w_state_next = ST_LD_CRC2;
      end
      ST_LD_CRC2: begin
        tx_load      = 1'b1;
        tx_byte      = w_crc_tx[15:8];
        w_state_next = ST_WT_CRC2;
      end
      ST_WT_CRC2: begin
        if (byte_done) w_state_next = ST_EOP;
      end
      ST_EOP: begin
        send_eop     = 1'b1;
        w_state_next = ST_WT_EOP;
      end
      ST_WT_EOP: begin
        if (eop_done) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        tx_done      = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_code   <= 3'd0;
      r_len    <= 7'd0;
      r_cnt    <= 7'd0;
      r_crc    <= 16'hFFFF;
      r_toggle <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && w_req_valid) begin
        r_code <= TX_packet;
        r_len  <= w_len_clamped;
        r_cnt  <= 7'd0;
        r_crc  <= 16'hFFFF;
      end
      if (r_state == ST_LD_DATA) begin
        r_crc <= w_crc_upd;
        r_cnt <= r_cnt + 7'd1;
      end
      // Toggle only advances once a DATA packet has fully completed.
      if (r_state == ST_DONE && r_code == PKT_DATA) begin
        r_toggle <= ~r_toggle;
      end
    end
  end

endmodule

// File: tb/tb_tx_control_fsm.sv
// Scoreboard bench for tx_control_fsm: stimulus queues expected load/EOP/done events,
// a monitor pops and compares them, and a small encoder/FIFO model answers the strobes.
module tb_tx_control_fsm;

  logic       clk;
  logic       n_rst;
  logic [2:0] TX_packet;
  logic [6:0] buffer_occupancy;
  logic [7:0] tx_data;
  logic       byte_done;
  logic       eop_done;
  logic [7:0] tx_byte;
  logic       tx_load;
  logic       get_tx_data;
  logic       send_eop;
  logic       tx_busy;
  logic       tx_done;

  localparam int EV_EOP  = 256;
  localparam int EV_DONE = 512;

  int         n_cmp;
  int         n_bad;
  int         exp_q[$];
  int         pops;
  int         loads_seen;
  int         rd_ptr;
  logic [7:0] fifo_mem [0:127];

  tx_control_fsm #(.MAX_BYTES(64)) dut (
    .clk              (clk),
    .n_rst            (n_rst),
    .TX_packet        (TX_packet),
    .buffer_occupancy (buffer_occupancy),
    .tx_data          (tx_data),
    .byte_done        (byte_done),
    .eop_done         (eop_done),
    .tx_byte          (tx_byte),
    .tx_load          (tx_load),
    .get_tx_data      (get_tx_data),
    .send_eop         (send_eop),
    .tx_busy          (tx_busy),
    .tx_done          (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign tx_data = fifo_mem[rd_ptr[6:0]];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Independent bit-serial reference: one input bit per step, LSB first.
  function automatic logic [15:0] model_crc(input int n);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ fifo_mem[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 16'hA001;
      end
    end
    return ~c;
  endfunction

  task automatic log_event(input int ev);
    int e;
    if (exp_q.size() == 0) begin
      check("unexpected_event", ev, -1);
    end else begin
      e = exp_q.pop_front();
      check("event", ev, e);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    pops = 0;
    loads_seen = 0;
    forever begin
      @(negedge clk);
      if (n_rst) begin
        if (tx_load) begin
          loads_seen++;
          log_event(int'(tx_byte));
        end
        if (send_eop) log_event(EV_EOP);
        if (tx_done)  log_event(EV_DONE);
        if (get_tx_data) pops++;
      end
    end
  end

  // FIFO pop: advance the head just after the edge that consumed it.
  initial begin
    rd_ptr = 0;
    forever begin
      @(posedge clk);
      if (n_rst && get_tx_data) begin
        #1;
        rd_ptr = rd_ptr + 1;
      end
    end
  end

  // Encoder model: byte_done two cycles after a load, eop_done three cycles after send_eop.
  initial begin
    byte_done = 1'b0;
    eop_done  = 1'b0;
    forever begin
      @(negedge clk);
      byte_done = 1'b0;
      eop_done  = 1'b0;
      if (n_rst && tx_load) begin
        repeat (2) @(negedge clk);
        byte_done = 1'b1;
      end else if (n_rst && send_eop) begin
        repeat (3) @(negedge clk);
        eop_done = 1'b1;
      end
    end
  end

  task automatic fill_digits();
    for (int i = 0; i < 128; i++) fifo_mem[i] = 8'h00;
    for (int i = 0; i < 9; i++) fifo_mem[i] = 8'h31 + 8'(i);
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < 128; i++) fifo_mem[i] = 8'(i * 37 + 5);
  endtask

  // crc_exp < 0 selects the reference model; otherwise the hand-computed transmitted CRC.
  task automatic run_pkt(input string name, input logic [2:0] code, input int occ,
                         input logic [7:0] pid, input int crc_exp, input bit hold_nak);
    int          len;
    int          t;
    logic [15:0] crc;
    len = 0;
    if (code == 3'd1) len = (occ > 64) ? 64 : occ;
    rd_ptr = 0;
    pops = 0;
    buffer_occupancy = 7'(occ);
    exp_q.push_back(8'h80);
    exp_q.push_back(int'(pid));
    if (code == 3'd1) begin
      for (int i = 0; i < len; i++) exp_q.push_back(int'(fifo_mem[i]));
      crc = (crc_exp < 0) ? model_crc(len) : 16'(crc_exp);
      exp_q.push_back(int'(crc[7:0]));
      exp_q.push_back(int'(crc[15:8]));
    end
    exp_q.push_back(EV_EOP);
    exp_q.push_back(EV_DONE);

    @(negedge clk);
    TX_packet = code;
    t = 0;
    while (!tx_busy && t < 5) begin
      @(negedge clk);
      t++;
    end
    check({name, "_start_latency"}, t, 1);
    TX_packet = hold_nak ? 3'd5 : 3'd0;
    if (hold_nak) begin
      repeat (5) @(negedge clk);
      TX_packet = 3'd0;
    end
    t = 0;
    while (!tx_done && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check({name, "_done_seen"}, int'(tx_done), 1);
    @(negedge clk);
    check({name, "_busy_drop"}, int'(tx_busy), 0);
    check({name, "_queue_drained"}, exp_q.size(), 0);
    check({name, "_pops"}, pops, len);
    $display("packet %s: code=%0d occ=%0d pid=%02h pops=%0d", name, code, occ, pid, pops);
    exp_q.delete();
  endtask

  initial begin
    int t;
    int loads_before;
    n_cmp = 0;
    n_bad = 0;
    n_rst = 1'b0;
    TX_packet = 3'd0;
    buffer_occupancy = 7'd0;
    fill_digits();

    #1;
    check("reset_outputs", int'({tx_load, get_tx_data, send_eop, tx_busy, tx_done}), 0);
    check("reset_tx_byte", int'(tx_byte), 0);
    repeat (3) @(negedge clk);
    #2 n_rst = 1'b1;
    repeat (2) @(negedge clk);

    run_pkt("ack", 3'd4, 0, 8'hD2, 0, 1'b0);
    run_pkt("data_digits", 3'd1, 9, 8'hC3, 16'hB4C8, 1'b0);
    run_pkt("ack_mid", 3'd4, 0, 8'hD2, 0, 1'b0);
    run_pkt("data_zero_len", 3'd1, 0, 8'h4B, 16'h0000, 1'b0);

    loads_before = loads_seen;
    for (int c = 2; c <= 6; c++) begin
      if (c == 4 || c == 5) continue;
      @(negedge clk);
      TX_packet = 3'(c);
      repeat (8) @(negedge clk);
      check($sformatf("ignored_code%0d_busy", c), int'(tx_busy), 0);
      TX_packet = 3'd0;
    end
    check("ignored_codes_no_load", loads_seen - loads_before, 0);
    $display("packet ignored_codes: loads=%0d", loads_seen - loads_before);

    fill_pattern();
    run_pkt("data_occ70", 3'd1, 70, 8'hC3, -1, 1'b1);

    // Reset in the middle of a DATA packet, while waiting on a payload byte.
    fill_digits();
    rd_ptr = 0;
    pops = 0;
    buffer_occupancy = 7'd9;
    exp_q.push_back(8'h80);
    exp_q.push_back(8'h4B);
    for (int i = 0; i < 3; i++) exp_q.push_back(int'(fifo_mem[i]));
    @(negedge clk);
    TX_packet = 3'd1;
    @(negedge clk);
    TX_packet = 3'd0;
    t = 0;
    while (pops < 3 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("midreset_reached_data", int'(pops >= 3), 1);
    if (get_tx_data) @(negedge clk);
    check("midreset_in_wait", int'({tx_busy, tx_load}), 2);
    #2 n_rst = 1'b0;
    #1;
    check("midreset_outputs", int'({tx_load, get_tx_data, send_eop, tx_busy, tx_done}), 0);
    check("midreset_tx_byte", int'(tx_byte), 0);
    check("midreset_queue", exp_q.size(), 0);
    $display("packet midreset: pops_before_reset=%0d", pops);
    exp_q.delete();
    repeat (3) @(negedge clk);
    #2 n_rst = 1'b1;
    repeat (10) @(negedge clk);

    run_pkt("data_after_reset", 3'd1, 9, 8'hC3, 16'hB4C8, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tx_control_fsm.md
# tx_control_fsm

Packet-level transmit controller for the USB CDL, the counterpart of the RX control FSM. It accepts a packet request from the protocol layer and sequences the packet byte by byte into the bit-level TX encoder/NRZI stage. Each packet is SYNC, then PID, then for DATA packets the payload from the TX FIFO and CRC16, then EOP. It maintains the DATA0/DATA1 toggle and computes CRC16 on the fly.

## Interface
- MAX_BYTES, 64, maximum DATA payload length; larger occupancies are clamped.
- clk  input  1  system clock, rising edge
- n_rst  input  1  asynchronous active-low reset
- TX_packet  input  3  request code, using the RX_PID encoding:
  - 0 IDLE, 1 DATA, 4 ACK, 5 NAK, 7 STALL.
  - Codes 2, 3 and 6 are ignored.
- buffer_occupancy  input  7  number of bytes held in the TX FIFO.
- tx_data  input  8  FIFO head byte, first-word-fall-through.
- byte_done  input  1  one-cycle pulse from the encoder: the loaded byte has been taken into its shift register and its holding register is free.
- eop_done  input  1  one-cycle pulse from the encoder when EOP signalling has finished.
- tx_byte  output  8  byte to send, bit 0 first. Valid only while tx_load=1.
- tx_load  output  1  load strobe to the encoder.
- get_tx_data  output  1  FIFO pop strobe.
- send_eop  output  1  EOP request strobe.
- tx_busy  output  1  high while a packet is in progress.
- tx_done  output  1  one-cycle pulse when the packet completes.

## Operation
- States: IDLE, LD_SYNC, WT_SYNC, LD_PID, WT_PID, LD_DATA, WT_DATA, LD_CRC1, WT_CRC1, LD_CRC2, WT_CRC2, EOP, WT_EOP, DONE.
- IDLE, on a valid TX_packet:
  - Latch the code.
  - Latch len = min(buffer_occupancy, MAX_BYTES).
  - Set crc = 16'hFFFF.
  - Go to LD_SYNC.
- Load states (LD_*, EOP): last exactly one cycle and then go to the matching WT_* state.
  - Each LD_* state drives tx_load=1.
  - EOP drives send_eop=1.
- Wait states: WT_* waits for byte_done; WT_EOP waits for eop_done.
- tx_byte per load state:
  - LD_SYNC: 8'h80.
  - LD_PID:
    - ACK 8'hD2, NAK 8'h5A, STALL 8'h1E.
    - DATA uses 8'hC3 (DATA0) or 8'h4B (DATA1), selected by the toggle.
- Sequencing after WT_PID:
  - ACK/NAK/STALL go to EOP.
  - DATA goes to LD_DATA if cnt<len, otherwise to LD_CRC1 (zero-length packet).
- LD_DATA:
  - tx_byte = tx_data.
  - get_tx_data=1 in the same cycle.
  - crc is updated with tx_data.
  - cnt increments.
- WT_DATA exit: go to LD_DATA while cnt<len, otherwise to LD_CRC1.
- CRC update, per byte:
  - crc ^= byte.
  - Then 8 iterations: if crc[0], crc = (crc>>1)^16'hA001; else crc = crc>>1.
  - This is reflected CRC-16/USB, polynomial 0x8005.
- CRC bytes sent:
  - LD_CRC1 sends (~crc)[7:0].
  - LD_CRC2 sends (~crc)[15:8].
  - After WT_CRC2, go to EOP.
- DONE:
  - tx_done=1 for one cycle.
  - For a DATA packet, invert the toggle.
  - Return to IDLE.
- Handled boundaries:
  - buffer_occupancy above 64 is clamped.
  - The FIFO is never popped more than len times.
  - Requests while tx_busy=1 are ignored; TX_packet may stay asserted.
  - A TX_packet still asserted when IDLE is re-entered starts a new packet.
- Unexpected strobes: byte_done in a non-WT state is ignored, and so is eop_done outside WT_EOP.

## Timing
- Reset (asynchronous, any state, including mid-packet):
  - State goes to IDLE and cnt=0.
  - Toggle returns to DATA0, crc=16'hFFFF.
  - All strobes are 0, tx_busy=0, tx_byte=8'h00.
- Latency: request seen in IDLE at edge N; LD_SYNC at cycle N+1, with tx_load high for that single cycle.
- tx_busy covers LD_SYNC through DONE inclusive.
- Strobes tx_load, get_tx_data, send_eop and tx_done are Moore outputs, each high exactly one cycle per occurrence.
- The next load is issued the cycle after byte_done. The encoder tolerates this one-cycle gap within a byte time.
- CRC register update: crc updates on the clock edge leaving LD_DATA. LD_CRC1 uses the value after the last data byte.

## Test plan
- ACK request (TX_packet=4):
  - Expect tx_byte sequence 80, D2, then send_eop.
  - After eop_done, tx_done pulses once and tx_busy drops the next cycle.
- Zero-length DATA with occupancy 0: expect bytes 80, C3, 00, 00, then EOP. There is no get_tx_data.
- DATA with FIFO "123456789" (31..39): expect 80, C3, 31..39, C8, B4, then EOP, with exactly 9 get_tx_data pulses.
- Two consecutive DATA packets: PIDs are C3 then 4B. After reset the PID is C3 again. An ACK between the two does not change the toggle.
- Occupancy 70: exactly 64 pops and 64 payload bytes. Also: TX_packet changed to NAK while busy is ignored. Codes 2, 3 and 6 produce no tx_load.
- Assert n_rst low in WT_DATA: all outputs return to 0 immediately. The next DATA request restarts at 80, C3 with a fresh CRC.
